// File: rtl/systolic_tile_seq_if.sv
// Host-side bus of the systolic tile sequencer: job control, operand stream and result handshake.
// master = host side, slave = sequencer side.
interface systolic_tile_seq_if #(
    parameter int unsigned LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic             op_valid;
    logic             op_ready;
    logic [15:0]      op_col;
    logic [15:0]      op_row;
    logic             res_valid;
    logic             res_ready;
    logic [63:0]      res_data;

    modport master (
        output start, len, op_valid, op_col, op_row, res_ready,
        input  busy, done, op_ready, res_valid, res_data
    );

    modport slave (
        input  start, len, op_valid, op_col, op_row, res_ready,
        output busy, done, op_ready, res_valid, res_data
    );
endinterface

// File: rtl/systolic_tile_seq.sv
// Host-side sequencer for one nibble-serial systolic tile: frames operands, drains and collects C0..C3.
// Optional LOOPBACK_CHECK_EN adds a sticky err output comparing operand loopback returns.
// start is sampled at the frame boundary (phase 3), so the host holds it until busy rises.
module systolic_tile_seq #(
    parameter int unsigned LEN_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    systolic_tile_seq_if.slave host,
    output logic [7:0]         tile_data,
    output logic [1:0]         tile_ctrl,
    input  logic [7:0]         tile_ret,
    input  logic [1:0]         tile_ctrl_ret,
    output logic [1:0]         phase
`ifdef LOOPBACK_CHECK_EN
    ,
    output logic               err
`endif
);

    localparam logic [3:0] CtrlDrainLo = 4'b1000;
    localparam logic [3:0] CtrlDrainHi = 4'b1100;

    typedef enum logic [2:0] {StIdle, StStream, StSlot, StDrain, StWait} state_e;

    state_e           state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [15:0]      col_q, col_d, row_q, row_d;
    logic [3:0]       ctrl_q, ctrl_d;

    logic [11:0]      ret_col_q, ret_col_d, ret_row_q, ret_row_d;
    logic [1:0]       ret_cadr_q, ret_cadr_d, ret_radr_q, ret_radr_d;
    logic [15:0]      c0_q, c0_d, c1_q, c1_d, c2_q, c2_d, c3_q, c3_d;
    logic [63:0]      res_data_q, res_data_d;
    logic             res_valid_q, res_valid_d;
    logic             done_q, done_d;

    logic             frame_end, op_fire, op_rdy, busy;
    logic             in_wait, col_lo, row_lo, col_hi, row_hi, res_capture;
    logic [15:0]      ret_col_word, ret_row_word;

    assign frame_end = (phase_q == 2'd3);
    assign op_fire   = host.op_valid && op_rdy;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            phase_q     <= 2'd0;
            rem_q       <= '0;
            col_q       <= '0;
            row_q       <= '0;
            ctrl_q      <= '0;
            ret_col_q   <= '0;
            ret_row_q   <= '0;
            ret_cadr_q  <= '0;
            ret_radr_q  <= '0;
            c0_q        <= '0;
            c1_q        <= '0;
            c2_q        <= '0;
            c3_q        <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            rem_q       <= rem_d;
            col_q       <= col_d;
            row_q       <= row_d;
            ctrl_q      <= ctrl_d;
            ret_col_q   <= ret_col_d;
            ret_row_q   <= ret_row_d;
            ret_cadr_q  <= ret_cadr_d;
            ret_radr_q  <= ret_radr_d;
            c0_q        <= c0_d;
            c1_q        <= c1_d;
            c2_q        <= c2_d;
            c3_q        <= c3_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            done_q      <= done_d;
        end
    end

    // Next state and next frame word; every decision happens at the frame boundary.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q + 2'd1;
        rem_d   = rem_q;
        col_d   = col_q;
        row_d   = row_q;
        ctrl_d  = ctrl_q;
        if (frame_end) begin
            // Bubble by default: the tile XOR-accumulates every frame, so idle frames must be zero.
            col_d  = '0;
            row_d  = '0;
            ctrl_d = '0;
            unique case (state_q)
                StIdle: begin
                    if (host.start) begin
                        rem_d   = host.len;
                        state_d = (host.len == '0) ? StSlot : StStream;
                    end
                end
                StStream: begin
                    if (op_fire) begin
                        col_d = host.op_col;
                        row_d = host.op_row;
                        rem_d = rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1)) begin
                            state_d = StSlot;
                        end
                    end
                end
                StSlot: begin
                    // An unconsumed result would be overwritten by the next drain, so hold off.
                    if (!res_valid_q) begin
                        ctrl_d  = CtrlDrainLo;
                        state_d = StDrain;
                    end
                end
                StDrain: begin
                    ctrl_d  = CtrlDrainHi;
                    state_d = StWait;
                end
                StWait: begin
                    if (res_capture) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM and frame outputs
    always_comb begin
        busy   = (state_q != StIdle);
        op_rdy = (state_q == StStream) && frame_end && (rem_q != '0);
        unique case (phase_q)
            2'd0: tile_data = {col_q[15:12], row_q[15:12]};
            2'd1: tile_data = {col_q[11:8], row_q[11:8]};
            2'd2: tile_data = {col_q[7:4], row_q[7:4]};
            2'd3: tile_data = {col_q[3:0], row_q[3:0]};
        endcase
        tile_ctrl = {2{ctrl_q[2'd3 - phase_q]}};
    end

    // Return path: three nibbles are held, the fourth is used live on the phase-3 edge.
    // Only ctrl bits [3:2] carry information, so just those are kept.
    always_comb begin
        ret_col_word = {ret_col_q, tile_ret[7:4]};
        ret_row_word = {ret_row_q, tile_ret[3:0]};
        ret_col_d    = ret_col_word[11:0];
        ret_row_d    = ret_row_word[11:0];
        ret_cadr_d   = ret_cadr_q;
        ret_radr_d   = ret_radr_q;
        if (!phase_q[1]) begin
            ret_cadr_d = {ret_cadr_q[0], tile_ctrl_ret[1]};
            ret_radr_d = {ret_radr_q[0], tile_ctrl_ret[0]};
        end

        in_wait     = (state_q == StWait) && frame_end;
        col_lo      = in_wait && (ret_cadr_q == 2'b10);
        row_lo      = in_wait && (ret_radr_q == 2'b10);
        col_hi      = in_wait && (ret_cadr_q == 2'b11);
        row_hi      = in_wait && (ret_radr_q == 2'b11);
        res_capture = col_hi || row_hi;

        c0_d = col_lo ? ret_col_word : c0_q;
        c1_d = row_lo ? ret_row_word : c1_q;
        c2_d = col_hi ? ret_col_word : c2_q;
        c3_d = row_hi ? ret_row_word : c3_q;

        res_data_d  = res_capture ? {c0_d, c1_d, c2_d, c3_d} : res_data_q;
        res_valid_d = res_valid_q;
        if (res_valid_q && host.res_ready) begin
            res_valid_d = 1'b0;
        end
        if (res_capture) begin
            res_valid_d = 1'b1;
        end
        done_d = res_capture;
    end

    assign phase          = phase_q;
    assign host.busy      = busy;
    assign host.done      = done_q;
    assign host.op_ready  = op_rdy;
    assign host.res_valid = res_valid_q;
    assign host.res_data  = res_data_q;

`ifdef LOOPBACK_CHECK_EN
    logic [15:0] prev_col_q, prev_col_d, prev_row_q, prev_row_d;
    logic        err_q, err_d;

    // The frame returning now is the one sent before the current frame word.
    always_comb begin
        prev_col_d = frame_end ? col_q : prev_col_q;
        prev_row_d = frame_end ? row_q : prev_row_q;
        err_d      = err_q;
        if (frame_end && !ret_cadr_q[1] && (ret_col_word != prev_col_q)) begin
            err_d = 1'b1;
        end
        if (frame_end && !ret_radr_q[1] && (ret_row_word != prev_row_q)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_col_q <= '0;
            prev_row_q <= '0;
            err_q      <= 1'b0;
        end else begin
            prev_col_q <= prev_col_d;
            prev_row_q <= prev_row_d;
            err_q      <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_systolic_tile_seq.sv
// Directed bench for systolic_tile_seq with a behavioural nibble-serial tile that XOR-accumulates
// {col byte, row byte} pairs into C0..C3 and loops operand frames back.
module tb_systolic_tile_seq;
    localparam int unsigned LEN_W = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tile_data;
    logic [1:0] tile_ctrl;
    logic [7:0] tile_ret = '0;
    logic [1:0] tile_ctrl_ret = '0;
    logic [1:0] phase;
`ifdef LOOPBACK_CHECK_EN
    logic       err;
    bit         inj = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int op_cnt = 0;

    systolic_tile_seq_if #(.LEN_W(LEN_W)) host_if ();

    systolic_tile_seq #(.LEN_W(LEN_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .host         (host_if),
        .tile_data    (tile_data),
        .tile_ctrl    (tile_ctrl),
        .tile_ret     (tile_ret),
        .tile_ctrl_ret(tile_ctrl_ret),
        .phase        (phase)
`ifdef LOOPBACK_CHECK_EN
        ,
        .err          (err)
`endif
    );

    always #5 clk = ~clk;

    // Tile model with its own phase counter, reset by the shared rst_n.
    logic [1:0]  t_ph;
    logic [11:0] t_col_sh, t_row_sh;
    logic [2:0]  t_cc_sh, t_rc_sh;
    logic [15:0] acc [4];
    logic [15:0] rsp_col, rsp_row;
    logic [3:0]  rsp_cc, rsp_rc;
    logic [15:0] f_col, f_row;
    logic [3:0]  f_cc, f_rc;

    assign f_col = {t_col_sh, tile_data[7:4]};
    assign f_row = {t_row_sh, tile_data[3:0]};
    assign f_cc  = {t_cc_sh, tile_ctrl[1]};
    assign f_rc  = {t_rc_sh, tile_ctrl[0]};

    always @(posedge clk) begin
        if (!rst_n) begin
            t_ph <= 2'd0;
            t_col_sh <= '0; t_row_sh <= '0; t_cc_sh <= '0; t_rc_sh <= '0;
            rsp_col <= '0; rsp_row <= '0; rsp_cc <= '0; rsp_rc <= '0;
            for (int i = 0; i < 4; i++) acc[i] <= '0;
        end else begin
            t_ph     <= t_ph + 2'd1;
            t_col_sh <= f_col[11:0];
            t_row_sh <= f_row[11:0];
            t_cc_sh  <= f_cc[2:0];
            t_rc_sh  <= f_rc[2:0];
            if (t_ph == 2'd3) begin
                rsp_cc <= f_cc;
                rsp_rc <= f_rc;
                case (f_cc[3:2])
                    2'b00: begin
                        acc[0]  <= acc[0] ^ {f_col[15:8], f_row[15:8]};
                        acc[1]  <= acc[1] ^ {f_col[7:0], f_row[15:8]};
                        acc[2]  <= acc[2] ^ {f_col[15:8], f_row[7:0]};
                        acc[3]  <= acc[3] ^ {f_col[7:0], f_row[7:0]};
                        rsp_col <= f_col;
                        rsp_row <= f_row;
                    end
                    2'b10: begin rsp_col <= acc[0]; rsp_row <= acc[1]; end
                    2'b11: begin rsp_col <= acc[2]; rsp_row <= acc[3]; end
                    default: begin rsp_col <= '0; rsp_row <= '0; end
                endcase
            end
        end
    end

    function automatic logic [3:0] nib(input logic [15:0] w, input logic [1:0] p);
        case (p)
            2'd0: nib = w[15:12];
            2'd1: nib = w[11:8];
            2'd2: nib = w[7:4];
            default: nib = w[3:0];
        endcase
    endfunction

    always @(negedge clk) begin
        tile_ret      <= {nib(rsp_col, t_ph), nib(rsp_row, t_ph)};
        tile_ctrl_ret <= {rsp_cc[2'd3 - t_ph], rsp_rc[2'd3 - t_ph]};
`ifdef LOOPBACK_CHECK_EN
        if (inj && !rsp_cc[3] && (rsp_col != '0) && (t_ph == 2'd0)) begin
            tile_ret <= {nib(rsp_col, t_ph) ^ 4'b0001, nib(rsp_row, t_ph)};
        end
`endif
    end

    always @(posedge clk) begin
        if (rst_n && host_if.done) done_cnt <= done_cnt + 1;
        if (rst_n && host_if.op_valid && host_if.op_ready) op_cnt <= op_cnt + 1;
    end

    // Stimulus helpers; all comparisons live in the test tasks.
    task automatic start_job(input int n, output bit ok);
        host_if.start = 1'b1;
        host_if.len   = LEN_W'(n);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (host_if.busy) begin ok = 1'b1; break; end
        end
        host_if.start = 1'b0;
    endtask

    task automatic send_op(input logic [15:0] c, input logic [15:0] r, output bit ok);
        host_if.op_valid = 1'b1;
        host_if.op_col   = c;
        host_if.op_row   = r;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (host_if.op_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        host_if.op_valid = 1'b0;
    endtask

    task automatic wait_result(output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            cyc++;
            if (host_if.res_valid) begin ok = 1'b1; break; end
        end
    endtask

    task automatic consume();
        host_if.res_ready = 1'b1;
        @(negedge clk);
        host_if.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [1:0] exp_ph;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({host_if.busy, host_if.done, host_if.op_ready, host_if.res_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags busy/done/ready/valid=%b want 0000",
                     {host_if.busy, host_if.done, host_if.op_ready, host_if.res_valid});
        end
        checks++;
        if (host_if.res_data !== 64'h0) begin
            errors++; $display("FAIL reset_res_data got %h want 0", host_if.res_data);
        end
        checks++;
        if ({tile_data, tile_ctrl} !== 10'h0) begin
            errors++; $display("FAIL reset_tile got %h/%b want 0/0", tile_data, tile_ctrl);
        end
        rst_n = 1'b1;
        exp_ph = 2'd0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (phase !== exp_ph) begin
                errors++; $display("FAIL phase_count step %0d got %0d want %0d", i, phase, exp_ph);
            end
            exp_ph = exp_ph + 2'd1;
            if (i < 4) @(negedge clk);
        end
    endtask

    task automatic test_basic();
        bit ok;
        int cyc;
        int d0;
        logic [31:0] nibs;
        logic [7:0]  ctls;
        d0 = done_cnt;
        start_job(1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_start busy never rose got 0 want 1"); end
        send_op(16'h1234, 16'hABCD, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_op not accepted got 0 want 1"); end
        nibs = '0;
        ctls = '0;
        for (int i = 0; i < 4; i++) begin
            nibs = {nibs[23:0], tile_data};
            ctls = {ctls[5:0], tile_ctrl};
            if (i < 3) @(negedge clk);
        end
        checks++;
        if (nibs !== 32'h1A2B3C4D) begin
            errors++; $display("FAIL basic_tile_data got %h want 1a2b3c4d", nibs);
        end
        checks++;
        if (ctls !== 8'h00) begin errors++; $display("FAIL basic_tile_ctrl got %h want 00", ctls); end
        wait_result(cyc, ok);
        checks++;
        if (!ok || cyc != 13) begin
            errors++; $display("FAIL basic_latency got %0d (valid=%0b) want 13", cyc, ok);
        end
        checks++;
        if (host_if.res_data !== 64'h12AB_34AB_12CD_34CD) begin
            errors++; $display("FAIL basic_res_data got %h want 12ab34ab12cd34cd", host_if.res_data);
        end
        checks++;
        if (host_if.done !== 1'b1 || host_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_busy got %b%b want 10", host_if.done, host_if.busy);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++; $display("FAIL basic_done_pulses got %0d want 1", done_cnt - d0);
        end
        consume();
        checks++;
        if (host_if.res_valid !== 1'b0) begin
            errors++; $display("FAIL basic_res_consume got %b want 0", host_if.res_valid);
        end
    endtask

    task automatic test_xor_cancel();
        bit ok;
        int cyc;
        start_job(1, ok);
        send_op(16'h1234, 16'hABCD, ok);
        wait_result(cyc, ok);
        checks++;
        if (!ok || host_if.res_data !== 64'h0) begin
            errors++; $display("FAIL xor_cancel got %h (valid=%0b) want 0", host_if.res_data, ok);
        end
        consume();
    endtask

    task automatic test_bubbles();
        bit ok, ok2, ok3;
        int cyc;
        int c0;
        bit bad;
        c0 = op_cnt;
        start_job(3, ok);
        send_op(16'h1100, 16'h2200, ok);
        repeat (3) @(negedge clk);
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (tile_data !== 8'h00 || tile_ctrl !== 2'b00) bad = 1'b1;
            if ((i == 3 || i == 7) && host_if.op_ready !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL bubble_frames got nonzero/unready want zero/ready"); end
        send_op(16'h0033, 16'h0044, ok2);
        send_op(16'h5000, 16'h0006, ok3);
        checks++;
        if (!(ok && ok2 && ok3)) begin
            errors++; $display("FAIL bubble_ops accepted flags %0b%0b%0b want 111", ok, ok2, ok3);
        end
        host_if.op_valid = 1'b1;
        host_if.op_col   = 16'hFFFF;
        host_if.op_row   = 16'hFFFF;
        wait_result(cyc, ok);
        host_if.op_valid = 1'b0;
        checks++;
        if (op_cnt - c0 != 3) begin
            errors++; $display("FAIL bubble_op_count got %0d want 3", op_cnt - c0);
        end
        checks++;
        if (!ok || host_if.res_data !== 64'h4122_3322_4142_3342) begin
            errors++;
            $display("FAIL bubble_res_data got %h want 4122332241423342", host_if.res_data);
        end
    endtask

    task automatic test_stall();
        bit ok;
        bit bad;
        bit found;
        int cyc;
        logic [15:0] seq;
        start_job(0, ok);
        bad = !ok;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (tile_data !== 8'h00 || tile_ctrl !== 2'b00) bad = 1'b1;
            if (host_if.busy !== 1'b1 || host_if.res_valid !== 1'b1) bad = 1'b1;
            if (host_if.res_data !== 64'h4122_3322_4142_3342) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL stall_slot got activity want bubbles and held result"); end
        consume();
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (tile_ctrl !== 2'b00) begin found = 1'b1; break; end
        end
        seq = '0;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            seq = {seq[13:0], tile_ctrl};
            if (tile_data !== 8'h00) bad = 1'b1;
            if (i < 7) @(negedge clk);
        end
        checks++;
        if (!found || seq !== 16'hC0F0 || bad) begin
            errors++; $display("FAIL stall_drain_ctrl got %h (data nonzero=%0b) want c0f0", seq, bad);
        end
        wait_result(cyc, ok);
        checks++;
        if (!ok || cyc + 7 != 12) begin
            errors++; $display("FAIL stall_latency got %0d want 12", cyc + 7);
        end
        checks++;
        if (host_if.res_data !== 64'h4122_3322_4142_3342) begin
            errors++;
            $display("FAIL stall_res_data got %h want 4122332241423342", host_if.res_data);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int cyc;
        for (int i = 0; i < 8; i++) begin
            if (phase == 2'd3) break;
            @(negedge clk);
        end
        host_if.start     = 1'b1;
        host_if.len       = '0;
        host_if.res_ready = 1'b1;
        @(negedge clk);
        host_if.start     = 1'b0;
        host_if.res_ready = 1'b0;
        checks++;
        if (host_if.busy !== 1'b1 || host_if.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept busy/valid got %b%b want 10", host_if.busy, host_if.res_valid);
        end
        wait_result(cyc, ok);
        checks++;
        if (!ok || host_if.res_data !== 64'h4122_3322_4142_3342) begin
            errors++; $display("FAIL b2b_res_data got %h want 4122332241423342", host_if.res_data);
        end
        consume();
    endtask

`ifdef LOOPBACK_CHECK_EN
    task automatic test_loopback();
        bit ok;
        int cyc;
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL loop_clean got %b want 0", err); end
        inj = 1'b1;
        start_job(1, ok);
        send_op(16'h0F0F, 16'h5555, ok);
        wait_result(cyc, ok);
        consume();
        inj = 1'b0;
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL loop_detect got %b want 1", err); end
        repeat (8) @(negedge clk);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL loop_sticky got %b want 1", err); end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL loop_reset got %b want 0", err); end
    endtask
`endif

    initial begin
        host_if.start     = 1'b0;
        host_if.len       = '0;
        host_if.op_valid  = 1'b0;
        host_if.op_col    = '0;
        host_if.op_row    = '0;
        host_if.res_ready = 1'b0;
        test_reset();
        test_basic();
        test_xor_cancel();
        test_bubbles();
        test_stall();
        test_back_to_back();
`ifdef LOOPBACK_CHECK_EN
        test_loopback();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/systolic_tile_seq.md
Name: systolic_tile_seq

Overview:
Host-side sequencer for one nibble-serial systolic tile.
- Accepts 16-bit column/row operand words and a job length from the host.
- Serializes each word into 4-cycle frames, MSB nibble first, with per-frame control words.
- Issues two drain frames, deserializes the tile's return stream and presents the four 16-bit accumulators as one result word.
- Shares clk/rst_n with the tile, so the phase counters of both stay aligned.

Parameters:
LEN_W, 8, width of the job-length input (operand frames per job, 0..2^LEN_W-1)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
start  in  1  job request, accepted only in IDLE
len  in  LEN_W  operand frames in the job
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse when res_valid rises
op_valid  in  1  operand word available
op_ready  out  1  operand accepted when valid&ready
op_col  in  16  column operand word
op_row  in  16  row operand word
res_valid  out  1  result held
res_ready  in  1  result consumed when valid&ready
res_data  out  64  {C0,C1,C2,C3}
tile_data  out  8  [7:4] column nibble, [3:0] row nibble (to tile ui_in)
tile_ctrl  out  2  [1] column ctrl bit, [0] row ctrl bit (to tile uio_in[3:2])
tile_ret  in  8  tile uo_out: [7:4] column return, [3:0] row return
tile_ctrl_ret  in  2  tile uio_out[1:0]
phase  out  2  frame phase counter

Behaviour:
Reset and phase:
- Reset clears everything: phase=0, FSM=IDLE, busy=0, done=0, op_ready=0, res_valid=0, res_data=0, tile_data=0, tile_ctrl=0.
- phase increments every clk and wraps 3->0. A frame is phase 0..3.

Transmit path:
- tile_data and tile_ctrl = nibble/bit [15-4p:12-4p] / [3-p] of the registered frame word, where p = phase.
- No combinational path from host inputs to tile outputs.
- The next frame word is loaded on the posedge where phase is 3.
- Ctrl word bits [3:2]: 00 operand, 10 drain C0/C1, 11 drain C2/C3. Bits [1:0] = 0.

Handshakes:
- op_ready=1 only in STREAM, only while phase==3, and only while operands remain.
- Operand transfer: op_valid&op_ready.
- If no operand transfers at phase 3 in STREAM, a bubble frame (data 0, ctrl 0) is loaded and the remaining count is unchanged.
- Drain and bubble frames carry zero data. The tile XOR-accumulates every frame, so these frames must be zero.

FSM (transitions evaluated at phase==3):
- IDLE: start -> STREAM with rem=len (len=0 -> SLOT directly). start is ignored in every other state.
- STREAM: rem decrements per accepted operand; rem==0 -> SLOT.
- SLOT: if res_valid==0, load drain frame addr 10 -> DRAIN; else load bubble and stay.
- DRAIN: load drain frame addr 11 -> WAIT.
- WAIT: load bubble frames until both drain returns are captured -> IDLE.

Return path:
- The tile drives nibble p of frame n's response on the falling edge during phase p of frame n+1.
- The sequencer samples tile_ret/tile_ctrl_ret on the posedge with phase==p into 16-bit/4-bit shift registers.
- After the phase-3 sample, the returned ctrl word is decoded:
  - Column addr 10 -> C0=col word; row addr 10 -> C1=row word.
  - Column addr 11 -> C2; row addr 11 -> C3.
  - Other return codes are ignored.
- When the C2/C3 return is captured: res_valid=1, done pulses, busy=0.
- Latency: the first drain loaded at the start of frame n gives res_valid in the first cycle of frame n+3.
- res_valid falls on res_ready. res_data holds while res_valid=1.
- A simultaneous start and res_ready in IDLE are both honoured.
- Reset mid-job aborts immediately. The tile is reset by the same rst_n.

Optional Feature:
LOOPBACK_CHECK_EN:
- Defined: adds output err (1 bit, reset 0). The sequencer keeps the previous frame's word. When a returned frame has ctrl addr 0x, the returned column/row words must equal the sent op_col/op_row; a mismatch sets err sticky until reset.
- Undefined: no err port and no compare logic.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles -> all outputs 0, phase 0, then phase counts 0,1,2,3,0.
- From reset, start len=1, op_col=0x1234, op_row=0xABCD -> tile_data nibbles 0x1A,0x2B,0x3C,0x4D; res_data=0x12AB_34AB_12CD_34CD; done pulses once.
- Repeat the same job without reset -> res_data=0 (XOR cancel).
- len=3 with op_valid low for 2 frames mid-job -> 2 bubble frames (tile_data=0, ctrl=0), exactly 3 operands accepted, correct result.
- Hold res_ready=0 and start a second job with len=0 -> FSM stalls in SLOT emitting bubbles; release res_ready -> the second result appears 3 frames after the drain.
- LOOPBACK_CHECK_EN: force tile_ret bit flip on an operand return -> err=1 and stays high; clean run -> err stays 0.
